// File: rtl/io_out_arbiter_pkg.sv
// io_pkg: shared types and helpers for the output-port write arbiter.
//   state_t        - sequencer states IDLE / WRITE / ACK
//   PORT_BASE_DEF  - default addr[7:2] value of output port 0 (byte 80h)
//   port_in_range  - true when addr[7:2] selects an implemented port
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [5:0] PORT_BASE_DEF = 6'b100000;

    // Only addr[7:2] is decoded; the upper bits and the byte offset are
    // ignored. Compared in 7 bits so base + nports cannot wrap.
    function automatic logic port_in_range(input logic [31:0] addr,
                                           input logic [5:0]  base,
                                           input int unsigned nports);
        logic [6:0] idx;
        logic [6:0] lo;
        logic [6:0] hi;
        idx = {1'b0, addr[7:2]};
        lo  = {1'b0, base};
        hi  = lo + nports[6:0];
        return (idx >= lo) && (idx < hi);
    endfunction

endpackage

// File: rtl/io_out_arbiter_rr_arb2.sv
// io_rr_arb2: combinational two-way round-robin pick.
//   req0, req1 - requests
//   last       - index of the previous winner
//   gsel       - selected requester (valid only when valid = 1)
//   valid      - at least one request is pending
module io_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gsel,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        // On a tie the requester that did not win last time goes next.
        if (req0 && req1) begin
            gsel = ~last;
        end else begin
            gsel = req1;
        end
    end

endmodule

// File: rtl/io_out_arbiter.sv
// io_out_arbiter: shares the output-port block's single write interface
// between the CPU store path (requester 0) and a secondary master
// (requester 1), and suppresses writes to unimplemented ports.
//   io_clk, reset          - clock, asynchronous active-high reset
//   reqN, addrN, dataN     - write request from requester N
//   ackN, errN             - one-cycle completion pulse; err = out of range
//   io_we, io_addr, io_wdata - write interface to the output-port block
//   busy                   - sequencer not in IDLE
module io_out_arbiter
    import io_pkg::*;
#(
    parameter int unsigned NPORTS    = 4,
    parameter logic [5:0]  PORT_BASE = PORT_BASE_DEF
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        err0,
    output logic        ack1,
    output logic        err1,
    output logic        io_we,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gsel_q, gsel_d;
    logic        inr_q, inr_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        err0_q, err0_d, err1_q, err1_d;

    logic        pick;
    logic        pick_valid;
    logic [31:0] win_addr;

    io_rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .gsel  (pick),
        .valid (pick_valid)
    );

    assign win_addr = pick ? addr1 : addr0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gsel_d  = gsel_q;
        inr_d   = inr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // The range check is evaluated on the winner's address
                    // at grant so the strobe can be registered for WRITE.
                    addr_d  = win_addr;
                    wdata_d = pick ? data1 : data0;
                    gsel_d  = pick;
                    last_d  = pick;
                    inr_d   = port_in_range(win_addr, PORT_BASE, NPORTS);
                    we_d    = inr_d;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                ack0_d  = ~gsel_q;
                ack1_d  = gsel_q;
                err0_d  = ~gsel_q & ~inr_q;
                err1_d  = gsel_q & ~inr_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gsel_q  <= 1'b0;
            inr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gsel_q  <= gsel_d;
            inr_q   <= inr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    assign io_we    = we_q;
    assign io_addr  = addr_q;
    assign io_wdata = wdata_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_io_out_arbiter.sv
// Directed bench for io_out_arbiter: a per-cycle vector table for the
// basic flows plus hand sequences for reset abort, input changes during
// WRITE, and sustained two-requester traffic.
module tb_io_out_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1, data0, data1;
    logic        ack0, ack1, err0, err1;
    logic        io_we, busy;
    logic [31:0] io_addr, io_wdata;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    io_out_arbiter #(.NPORTS(4), .PORT_BASE(6'b100000)) dut (
        .io_clk   (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .data0    (data0),
        .req1     (req1),
        .addr1    (addr1),
        .data1    (data1),
        .ack0     (ack0),
        .err0     (err0),
        .ack1     (ack1),
        .err1     (err1),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .busy     (busy)
    );

    typedef struct {
        logic        r0;
        logic [31:0] a0, d0;
        logic        r1;
        logic [31:0] a1, d1;
        logic        we;
        logic [31:0] ia, iw;
        logic        k0, e0, k1, e1, bz;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic we, input logic [31:0] ia, input logic [31:0] iw,
                       input logic k0, input logic e0, input logic k1, input logic e1,
                       input logic bz);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
        v.we = we; v.ia = ia; v.iw = iw;
        v.k0 = k0; v.e0 = e0; v.k1 = k1; v.e1 = e1; v.bz = bz;
        vq.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        #1;
        chk("rst_we", {31'd0, io_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", io_addr, 32'd0);
        chk("rst_wdata", io_wdata, 32'd0);
        chk("rst_acks", {28'd0, ack0, err0, ack1, err1}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;

        // single write to port 0
        add(1, 32'h80, 32'h12345678, 0, 0, 0,  1, 32'h80, 32'h12345678, 0,0,0,0, 1);
        add(1, 32'h80, 32'h12345678, 0, 0, 0,  0, 32'h80, 32'h12345678, 1,0,0,0, 1);
        add(1, 32'h80, 32'h12345678, 0, 0, 0,  0, 32'h80, 32'h12345678, 0,0,0,0, 0);
        // requester 1 to 0x90: one past the last port
        add(0, 0, 0, 1, 32'h90, 32'h55,       0, 32'h90, 32'h55, 0,0,0,0, 1);
        add(0, 0, 0, 1, 32'h90, 32'h55,       0, 32'h90, 32'h55, 0,0,1,1, 1);
        add(0, 0, 0, 1, 32'h90, 32'h55,       0, 32'h90, 32'h55, 0,0,0,0, 0);
        // simultaneous requests, last = 1 so requester 0 goes first
        add(1, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 1, 32'h84, 32'hAAAA0001, 0,0,0,0, 1);
        add(1, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 0, 32'h84, 32'hAAAA0001, 1,0,0,0, 1);
        add(1, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 0, 32'h84, 32'hAAAA0001, 0,0,0,0, 0);
        add(0, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 1, 32'h88, 32'hBBBB0002, 0,0,0,0, 1);
        add(0, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 0, 32'h88, 32'hBBBB0002, 0,0,1,0, 1);
        add(0, 32'h84, 32'hAAAA0001, 1, 32'h88, 32'hBBBB0002, 0, 32'h88, 32'hBBBB0002, 0,0,0,0, 0);
        // below PORT_BASE (addr[7:2] = 0x1F) -> error, no write
        add(1, 32'h17C, 32'hC0FFEE, 0, 0, 0,  0, 32'h17C, 32'hC0FFEE, 0,0,0,0, 1);
        add(1, 32'h17C, 32'hC0FFEE, 0, 0, 0,  0, 32'h17C, 32'hC0FFEE, 1,1,0,0, 1);
        add(1, 32'h17C, 32'hC0FFEE, 0, 0, 0,  0, 32'h17C, 32'hC0FFEE, 0,0,0,0, 0);
        // upper bits and byte offset ignored by the range check
        add(1, 32'hFFFFFF83, 32'hDEADBEEF, 0, 0, 0, 1, 32'hFFFFFF83, 32'hDEADBEEF, 0,0,0,0, 1);
        add(1, 32'hFFFFFF83, 32'hDEADBEEF, 0, 0, 0, 0, 32'hFFFFFF83, 32'hDEADBEEF, 1,0,0,0, 1);
        add(1, 32'hFFFFFF83, 32'hDEADBEEF, 0, 0, 0, 0, 32'hFFFFFF83, 32'hDEADBEEF, 0,0,0,0, 0);
        // last port (0x8C) is in range
        add(0, 0, 0, 1, 32'h8C, 32'h77,       1, 32'h8C, 32'h77, 0,0,0,0, 1);
        add(0, 0, 0, 1, 32'h8C, 32'h77,       0, 32'h8C, 32'h77, 0,0,1,0, 1);
        add(0, 0, 0, 1, 32'h8C, 32'h77,       0, 32'h8C, 32'h77, 0,0,0,0, 0);

        foreach (vq[i]) begin
            req0 = vq[i].r0; addr0 = vq[i].a0; data0 = vq[i].d0;
            req1 = vq[i].r1; addr1 = vq[i].a1; data1 = vq[i].d1;
            tick();
            chk($sformatf("v%0d_we", i), {31'd0, io_we}, {31'd0, vq[i].we});
            chk($sformatf("v%0d_addr", i), io_addr, vq[i].ia);
            chk($sformatf("v%0d_wdata", i), io_wdata, vq[i].iw);
            chk($sformatf("v%0d_ackerr", i), {28'd0, ack0, err0, ack1, err1},
                {28'd0, vq[i].k0, vq[i].e0, vq[i].k1, vq[i].e1});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vq[i].bz});
        end
        req0 = 0; req1 = 0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // inputs changed during WRITE are ignored
        req0 = 1; addr0 = 32'h88; data0 = 32'hCAFE0088;
        tick();
        chk("chg_we", {31'd0, io_we}, 32'd1);
        addr0 = 32'h9C; data0 = 32'h0;
        tick();
        chk("chg_addr", io_addr, 32'h88);
        chk("chg_wdata", io_wdata, 32'hCAFE0088);
        chk("chg_ack0", {30'd0, ack0, err0}, 32'd2);
        req0 = 0;
        tick();
        chk("chg_hold", io_addr, 32'h88);
        chk("chg_busy", {31'd0, busy}, 32'd0);

        // reset during WRITE aborts without needing a clock edge
        req0 = 1; addr0 = 32'h84; data0 = 32'h1111;
        tick();
        chk("abort_we_pre", {31'd0, io_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_we", {31'd0, io_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_acks", {30'd0, ack0, ack1}, 32'd0);
        req0 = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        req0 = 1; addr0 = 32'h8C; data0 = 32'h2222;
        tick();
        chk("post_we", {31'd0, io_we}, 32'd1);
        chk("post_addr", io_addr, 32'h8C);
        chk("post_wdata", io_wdata, 32'h2222);
        tick();
        chk("post_ack", {30'd0, ack0, err0}, 32'd2);
        req0 = 0;
        tick();
        chk("post_busy", {31'd0, busy}, 32'd0);

        // sustained traffic from both requesters alternates 0,1,0,1,0,1
        reset = 1'b1; #1; reset = 1'b0;
        req0 = 1; addr0 = 32'h80; data0 = 32'h100;
        req1 = 1; addr1 = 32'h84; data1 = 32'h101;
        for (int t = 0; t < 6; t++) begin
            logic w;
            w = logic'(t % 2);
            tick();
            chk($sformatf("rr%0d_we", t), {31'd0, io_we}, 32'd1);
            chk($sformatf("rr%0d_addr", t), io_addr, w ? 32'h84 : 32'h80);
            tick();
            chk($sformatf("rr%0d_acks", t), {30'd0, ack0, ack1}, w ? 32'd1 : 32'd2);
            if (t == 5) begin
                req0 = 0; req1 = 0;
            end
            tick();
            chk($sformatf("rr%0d_idle", t), {31'd0, busy}, 32'd0);
        end
        tick();
        chk("rr_quiet_busy", {31'd0, busy}, 32'd0);
        chk("rr_quiet_acks", {30'd0, ack0, ack1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
